// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronises the serial line, centre-samples each bit and
// presents good bytes with a one-cycle done strobe, or a one-cycle framing-error strobe.
module uart_rx_core #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       RX_En_Sig,
   input  logic       RX_Pin_In,
   output logic [7:0] RX_Data,
   output logic       RX_Done_Sig,
   output logic       RX_Err_Sig,
   output logic       RX_Busy
);

   localparam int unsigned BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t          state_q;
   logic [1:0]      sync_q;
   logic [BW-1:0]   bcnt_q;
   logic [BW-1:0]   bcnt_d;
   logic [2:0]      bidx_q;
   logic [7:0]      sh_q;
   logic [7:0]      data_q;
   logic            done_q;
   logic            err_q;
   logic            busy_q;
   logic            rxs;

   // NOTE: the synchroniser resets to 1 (line idle level) so reset release never looks like a start bit.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], RX_Pin_In};
      end
   end

   assign rxs    = sync_q[1];
   assign bcnt_d = bcnt_q + BW'(1);

   // NOTE: all state below updates with non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= S_IDLE;
         bcnt_q  <= '0;
         bidx_q  <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (RX_En_Sig && !rxs) begin
                  state_q <= S_START;
                  bcnt_q  <= '0;
                  busy_q  <= 1'b1;
               end
            end

            S_START: begin
               if (bcnt_q == HALF_LAST) begin
                  bcnt_q <= '0;
                  bidx_q <= '0;
                  if (!rxs) begin
                     state_q <= S_DATA;
                  end else begin
                     // Line back high at mid start bit: treat as noise.
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  bcnt_q <= bcnt_d;
               end
            end

            S_DATA: begin
               if (bcnt_q == BIT_LAST) begin
                  sh_q   <= {rxs, sh_q[7:1]};
                  bcnt_q <= '0;
                  if (bidx_q == 3'd7) begin
                     state_q <= S_STOP;
                  end else begin
                     bidx_q <= bidx_q + 3'd1;
                  end
               end else begin
                  bcnt_q <= bcnt_d;
               end
            end

            S_STOP: begin
               if (bcnt_q == BIT_LAST) begin
                  bcnt_q <= '0;
                  if (rxs) begin
                     data_q  <= sh_q;
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= S_WAIT_IDLE;
                  end
               end else begin
                  bcnt_q <= bcnt_d;
               end
            end

            S_WAIT_IDLE: begin
               // A held-low line (break) is reported once, then ignored until it idles.
               if (rxs) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= S_IDLE;
               bcnt_q  <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign RX_Data     = data_q;
   assign RX_Done_Sig = done_q;
   assign RX_Err_Sig  = err_q;
   assign RX_Busy     = busy_q;

   a_strobes_exclusive: assert property (@(posedge CLK) disable iff (!RSTn)
      !(done_q && err_q));

   a_done_single: assert property (@(posedge CLK) disable iff (!RSTn)
      done_q |=> !done_q);

   a_err_single: assert property (@(posedge CLK) disable iff (!RSTn)
      err_q |=> !err_q);

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomised bench for uart_rx_core: a waveform-level model predicts each frame's
// outcome from the sample-point rules, and a scoreboard compares strobes, cycles and data.
module tb_uart_rx_core;

   localparam int N   = 16;
   localparam int LAT = 3 + N / 2 + 9 * N;  // pin drive cycle -> strobe cycle

   typedef struct {
      int         cyc;
      bit         err;
      logic [7:0] data;
   } evt_t;

   logic       clk;
   logic       rst_n;
   logic       rx_en;
   logic       rx_pin;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rx_err;
   logic       rx_busy;

   int         cyc       = 0;
   int         n_checks  = 0;
   int         n_errors  = 0;
   int         both_high = 0;
   evt_t       exp_q[$];
   evt_t       obs_q[$];
   logic [7:0] last_good;

   uart_rx_core #(.CLKS_PER_BIT(N)) dut (
      .CLK         (clk),
      .RSTn        (rst_n),
      .RX_En_Sig   (rx_en),
      .RX_Pin_In   (rx_pin),
      .RX_Data     (rx_data),
      .RX_Done_Sig (rx_done),
      .RX_Err_Sig  (rx_err),
      .RX_Busy     (rx_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (rx_done === 1'b1 || rx_err === 1'b1)
            obs_q.push_back(evt_t'{cyc: cyc, err: (rx_err === 1'b1), data: rx_data});
         if (rx_done === 1'b1 && rx_err === 1'b1)
            both_high++;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Line level at 'rel' cycles after the start-bit edge, for a sender with bit period 'period'.
   function automatic logic pin_at(input int rel, input logic [7:0] d, input int period,
                                   input logic stop, input logic idle_after);
      int idx;
      idx = rel / period;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      if (idx == 9) return stop;
      return idle_after;
   endfunction

   task automatic expect_frame(input int p, input logic [7:0] d, input int period,
                               input logic stop, input logic idle_after);
      logic [7:0] b;
      logic       s;
      for (int k = 0; k < 8; k++)
         b[k] = pin_at(N / 2 + (k + 1) * N, d, period, stop, idle_after);
      s = pin_at(N / 2 + 9 * N, d, period, stop, idle_after);
      if (s) begin
         exp_q.push_back(evt_t'{cyc: p + LAT, err: 1'b0, data: b});
         last_good = b;
      end else begin
         exp_q.push_back(evt_t'{cyc: p + LAT, err: 1'b1, data: last_good});
      end
   endtask

   // Called and returns 1 time unit after a rising edge.
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input int period, input logic stop,
                             input int nbits, output int p);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      p = cyc;
      for (int j = 0; j < nbits; j++) begin
         rx_pin = bits[j];
         idle(period);
      end
   endtask

   task automatic compare_logs(input string tag);
      check({tag, "_count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check($sformatf("%s_cyc%0d", tag, i), obs_q[i].cyc, exp_q[i].cyc);
         check($sformatf("%s_err%0d", tag, i), 32'(obs_q[i].err), 32'(exp_q[i].err));
         check($sformatf("%s_data%0d", tag, i), obs_q[i].data, exp_q[i].data);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int         p;
      int         p1;
      int         p2;
      int         r;
      int         per;
      logic [7:0] d;

      rst_n     = 1'b0;
      rx_en     = 1'b1;
      rx_pin    = 1'b1;
      last_good = 8'h00;
      idle(3);
      check("rst_data", rx_data, 8'h00);
      check("rst_done", rx_done, 1'b0);
      check("rst_err",  rx_err,  1'b0);
      check("rst_busy", rx_busy, 1'b0);
      rst_n = 1'b1;
      idle(4);

      // Single byte
      send_frame(8'hA5, N, 1'b1, 10, p);
      expect_frame(p, 8'hA5, N, 1'b1, 1'b1);
      idle(20);
      compare_logs("single");
      check("single_hold", rx_data, 8'hA5);

      // Back-to-back frames, no idle gap
      send_frame(8'h00, N, 1'b1, 10, p);
      send_frame(8'hFF, N, 1'b1, 10, p1);
      send_frame(8'h3C, N, 1'b1, 10, p2);
      expect_frame(p,  8'h00, N, 1'b1, 1'b0);
      expect_frame(p1, 8'hFF, N, 1'b1, 1'b0);
      expect_frame(p2, 8'h3C, N, 1'b1, 1'b1);
      idle(20);
      compare_logs("b2b");

      // Framing error followed by a 40-bit break
      send_frame(8'h55, N, 1'b0, 10, p);
      expect_frame(p, 8'h55, N, 1'b0, 1'b0);
      idle(40 * N);
      check("break_busy", rx_busy, 1'b1);
      rx_pin = 1'b1;
      r = cyc;
      idle(2);
      check("break_busy_r2", rx_busy, 1'b1);
      idle(1);
      check("break_busy_r3", rx_busy, 1'b0);
      check("break_rel_cyc", cyc - r, 3);
      compare_logs("ferr");
      check("ferr_hold", rx_data, 8'h3C);
      send_frame(8'h96, N, 1'b1, 10, p);
      expect_frame(p, 8'h96, N, 1'b1, 1'b1);
      idle(20);
      compare_logs("after_ferr");

      // Glitch rejection: 3-cycle low pulse
      rx_pin = 1'b0;
      p = cyc;
      idle(3);
      rx_pin = 1'b1;
      idle(7);
      check("glitch_busy_t8", rx_busy, 1'b1);
      idle(1);
      check("glitch_busy_t9", rx_busy, 1'b0);
      check("glitch_rel_cyc", cyc - p, 11);
      idle(40);
      compare_logs("glitch");

      // Receiver disabled for a whole frame
      rx_en = 1'b0;
      send_frame(8'h81, N, 1'b1, 10, p);
      idle(40);
      check("dis_busy", rx_busy, 1'b0);
      rx_en = 1'b1;
      idle(4);
      compare_logs("disabled");

      // Reset during data bit 4
      send_frame(8'h5A, N, 1'b1, 5, p);
      idle(4);
      check("mid_busy", rx_busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_data", rx_data, 8'h00);
      check("midrst_done", rx_done, 1'b0);
      check("midrst_err",  rx_err,  1'b0);
      check("midrst_busy", rx_busy, 1'b0);
      rx_pin = 1'b1;
      @(posedge clk);
      idle(3);
      rst_n     = 1'b1;
      last_good = 8'h00;
      idle(20);
      compare_logs("rst_release");
      check("rel_data", rx_data, 8'h00);
      send_frame(8'hE7, N, 1'b1, 10, p);
      expect_frame(p, 8'hE7, N, 1'b1, 1'b1);
      idle(20);
      compare_logs("after_rst");

      // Sender baud offset: 15 and 17 cycles per bit
      send_frame(8'hC3, 15, 1'b1, 10, p);
      expect_frame(p, 8'hC3, 15, 1'b1, 1'b1);
      idle(40);
      compare_logs("baud15");
      check("baud15_data", rx_data, 8'hC3);
      last_good = 8'h00;
      send_frame(8'h00, N, 1'b1, 10, p);
      expect_frame(p, 8'h00, N, 1'b1, 1'b1);
      idle(20);
      compare_logs("baud_sep");
      send_frame(8'hC3, 17, 1'b1, 10, p);
      expect_frame(p, 8'hC3, 17, 1'b1, 1'b1);
      idle(40);
      compare_logs("baud17");
      check("baud17_data", rx_data, 8'hC3);

      // Random bytes, random sender period 15..17, random idle gaps
      for (int i = 0; i < 16; i++) begin
         d   = 8'($urandom);
         per = $urandom_range(17, 15);
         send_frame(d, per, 1'b1, 10, p);
         expect_frame(p, d, per, 1'b1, 1'b1);
         idle($urandom_range(48, 16));
      end
      idle(30);
      compare_logs("rand");

      check("strobes_exclusive", both_high, 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Receive-side UART block: 8N1 frames arrive on `RX_Pin_In`; each valid byte is presented on `RX_Data` with a one-cycle `RX_Done_Sig` strobe. It is the counterpart to the transmit path and runs on the same system clock. It synchronises the asynchronous pin and detects the start bit. It samples each bit at its centre and checks the stop bit, flagging framing errors. Downstream logic consumes bytes directly; there is no FIFO.

## Interface
- `CLKS_PER_BIT`, default 434: system clocks per bit period (50 MHz / 115200). Legal range 8..65535.
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RSTn`  in  1  reset, asynchronous, active-low.
- `RX_En_Sig`  in  1  receive enable. While 0, the FSM holds in IDLE and ignores the line.
- `RX_Pin_In`  in  1  serial line, asynchronous to `CLK`; idles high.
- `RX_Data`  out  8  last correctly received byte, LSB = first data bit.
- `RX_Done_Sig`  out  1  one-cycle pulse: `RX_Data` is updated and valid.
- `RX_Err_Sig`  out  1  one-cycle pulse: stop bit sampled low (framing error).
- `RX_Busy`  out  1  high in START, DATA, STOP and WAIT_IDLE.

## Operation
- **Synchroniser.** Two-flop synchroniser on `RX_Pin_In`; both flops reset to 1. All decisions use the second flop, called `rxs`.
- **Counters.**
  - Baud counter `bcnt`, width ceil(log2(CLKS_PER_BIT)).
  - Bit index `bidx`, 3 bits.
  - Shift register `sh`, 8 bits; bits enter at the MSB and shift right.
- **IDLE.**
  - If `RX_En_Sig`=1 and `rxs`=0, go to START with `bcnt`=0.
- **START.** `bcnt` increments each cycle. At `bcnt`=CLKS_PER_BIT/2−1 (integer division), sample `rxs`:
  - 0: valid start. Go to DATA with `bcnt`=0 and `bidx`=0.
  - 1: glitch. Return to IDLE with no strobe.
- **DATA.** `bcnt` increments. At `bcnt`=CLKS_PER_BIT−1:
  - shift `rxs` into `sh`;
  - set `bcnt`=0;
  - if `bidx`=7, go to STOP; otherwise increment `bidx`.
- **STOP.** At `bcnt`=CLKS_PER_BIT−1, sample `rxs`:
  - 1: load `RX_Data`←`sh`, pulse `RX_Done_Sig`, go to IDLE.
  - 0: pulse `RX_Err_Sig`, leave `RX_Data` unchanged, go to WAIT_IDLE.
- **WAIT_IDLE.**
  - Stay until `rxs`=1, then go to IDLE.
  - A held-low line (break) therefore produces exactly one error, not repeated frames.
- **Enable and reset behaviour.**
  - `RX_En_Sig` falling mid-frame does not abort; the frame completes. The FSM re-evaluates enable only in IDLE.
  - `RSTn` low mid-frame: immediately IDLE, counters 0, `sh`=0, no strobe on release.
  - After reset release, a line already low is treated as a start; the bench keeps the line high across reset.
- **Outputs.**
  - `RX_Done_Sig` and `RX_Err_Sig` are registered. They are never high together and never high for more than one cycle per frame.

## Timing
- **Reset values.** `RX_Data`=8'h00, `RX_Done_Sig`=0, `RX_Err_Sig`=0, `RX_Busy`=0, state=IDLE.
- **Synchroniser latency.** 2 cycles from pin edge to `rxs`.
- **Reference point.** Let t0 be the first cycle in which IDLE sees `rxs`=0, and let N=CLKS_PER_BIT.
- **Sample points.**
  - Start-bit sample at t0+N/2.
  - Data bit k sampled at t0+N/2+(k+1)·N.
  - Stop sample at t0+N/2+9N.
- **Strobe timing.** `RX_Done_Sig`/`RX_Err_Sig` are high in the cycle after the stop sample, together with the new `RX_Data`.
- **Back-to-back frames.** The FSM is back in IDLE one cycle after the stop sample, about N/2 before the nominal end of the stop bit. Back-to-back frames with one stop bit are therefore accepted.
- **Baud tolerance.** Tolerates ±4% sender baud error at N≥16.

## Test plan
- **Single byte.** N=16; send 0xA5 (8N1) with line idle high. Expect one `RX_Done_Sig` pulse at t0+8+144+1 and `RX_Data`=0xA5. `RX_Err_Sig` stays 0.
- **Back-to-back.** Send 0x00, 0xFF, 0x3C with no idle gap. Expect three done pulses 160 cycles apart, with data in order. No errors.
- **Framing error.** Send 0x55 with the stop bit driven 0, then hold low for 40 bit times, then release. Expect exactly one `RX_Err_Sig` pulse and `RX_Data` holding its previous value. `RX_Busy` stays 1 until the line goes high. The next valid frame is received correctly.
- **Glitch rejection.** Drive a 3-cycle low pulse on an idle line. Expect a return to IDLE, no strobes, and `RX_Busy` low again by t0+9.
- **Enable and reset.**
  - `RX_En_Sig`=0 while 0x81 is sent: expect no strobes.
  - Assert `RSTn` low at bit 4 of a frame: all outputs show reset values immediately.
  - A frame sent after release is received correctly.
- **Sampling tolerance.** Sender bit period 15 and then 17 cycles, with N=16. Expect 0xC3 to be received correctly in both cases.
